// File: rtl/hangman_pkg.sv
// Shared widths, codes and scanner state type for the hangman word scanner.
package hangman_pkg;
   localparam int CHAR_W  = 5;
   localparam int ADDR_W  = 5;
   localparam int MAX_LEN = 16;
   localparam int IDX_W   = $clog2(MAX_LEN);

   localparam logic [CHAR_W-1:0] KEY_NONE = '0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_DRAIN
   } scan_state_t;

   function automatic logic [ADDR_W-1:0] clamp_len(input logic [ADDR_W-1:0] len);
      return (len > ADDR_W'(MAX_LEN)) ? ADDR_W'(MAX_LEN) : len;
   endfunction
endpackage

// File: rtl/guess_scanner_scan_cmp_stage.sv
// Address walker plus 2-edge compare pipeline against the word RAM;
// owns the per-position hit/reveal masks.
module scan_cmp_stage
   import hangman_pkg::*;
(
   input  logic               clk,
   input  logic               i_rst,
   input  logic               i_clear_word,
   input  logic               i_start,
   input  logic               i_launch,
   input  logic [ADDR_W-1:0]  i_len,
   input  logic [CHAR_W-1:0]  i_guess,
   input  logic [CHAR_W-1:0]  i_ram_q,
   output logic [ADDR_W-1:0]  o_ram_addr,
   output logic               o_hit,
   output logic               o_last,
   output logic [MAX_LEN-1:0] o_hit_mask,
   output logic [MAX_LEN-1:0] o_revealed
);
   logic               r_issue;
   logic [ADDR_W-1:0]  r_addr;
   logic               r_cmp_valid;
   logic [IDX_W-1:0]   r_cmp_idx;
   logic [MAX_LEN-1:0] r_hit_mask;
   logic [MAX_LEN-1:0] r_revealed;
   logic               w_addr_end;
   logic               w_hit;
   logic               w_last;

   // r_cmp_idx trails r_addr by one edge, matching the RAM's registered read.
   assign w_addr_end = (r_addr == i_len - ADDR_W'(1));
   assign w_hit      = r_cmp_valid && (i_ram_q == i_guess) && !r_revealed[r_cmp_idx];
   assign w_last     = r_cmp_valid && (ADDR_W'(r_cmp_idx) == i_len - ADDR_W'(1));

   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_issue     <= 1'b0;
         r_addr      <= '0;
         r_cmp_valid <= 1'b0;
         r_cmp_idx   <= '0;
         r_hit_mask  <= '0;
         r_revealed  <= '0;
      end else if (i_clear_word) begin
         r_issue     <= 1'b0;
         r_cmp_valid <= 1'b0;
         r_hit_mask  <= '0;
         r_revealed  <= '0;
      end else begin
         r_cmp_valid <= r_issue;
         r_cmp_idx   <= r_addr[IDX_W-1:0];
         if (i_launch) begin
            r_addr  <= '0;
            r_issue <= 1'b1;
         end else if (r_issue) begin
            if (w_addr_end) r_issue <= 1'b0;
            else            r_addr  <= r_addr + ADDR_W'(1);
         end
         if (i_start) r_hit_mask <= '0;
         if (w_hit) begin
            r_hit_mask[r_cmp_idx] <= 1'b1;
            r_revealed[r_cmp_idx] <= 1'b1;
         end
      end
   end

   assign o_ram_addr = r_addr;
   assign o_hit      = w_hit;
   assign o_last     = w_last;
   assign o_hit_mask = r_hit_mask;
   assign o_revealed = r_revealed;
endmodule

// File: rtl/guess_scanner.sv
// Guess scanner: walks the stored word on a start request and reports hits.
// Optional repeated-guess detection under GUESS_SCANNER_REPEAT_EN.
//   state   | meaning
//   S_IDLE  | waiting for start
//   S_SCAN  | reads/compares in flight (one empty cycle when skipping)
//   S_DRAIN | publish match/done, drop busy
module guess_scanner
   import hangman_pkg::*;
(
   input  logic               clk,
   input  logic               resetn,
   input  logic               new_word,
   input  logic [ADDR_W-1:0]  word_len,
   input  logic               start,
   input  logic [CHAR_W-1:0]  guess,
   output logic [ADDR_W-1:0]  ram_addr,
   input  logic [CHAR_W-1:0]  ram_q,
   output logic               busy,
   output logic               done,
   output logic               match,
   output logic [ADDR_W-1:0]  hit_count,
   output logic [MAX_LEN-1:0] hit_mask,
   output logic [MAX_LEN-1:0] revealed,
   output logic [ADDR_W-1:0]  remain,
   output logic               all_found
`ifdef GUESS_SCANNER_REPEAT_EN
   ,
   output logic               is_repeat
`endif
);
   scan_state_t       r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_len, r_hit_count, r_remain;
   logic [CHAR_W-1:0] r_g;
   logic              r_skip, r_busy, r_done, r_match;
   logic              w_start_ok, w_skip, w_launch, w_hit, w_last, w_rep;

`ifdef GUESS_SCANNER_REPEAT_EN
   logic [(2**CHAR_W)-1:0] r_hist;
   logic                   r_rep, r_repeat;
   assign w_rep = r_hist[guess];
`else
   assign w_rep = 1'b0;
`endif

   assign w_start_ok = start && (r_state == S_IDLE) && !new_word;
   assign w_skip     = (r_len == '0) || (guess == KEY_NONE) || w_rep;
   assign w_launch   = w_start_ok && !w_skip;

   scan_cmp_stage u_cmp (
      .clk          (clk),
      .i_rst        (resetn),
      .i_clear_word (new_word),
      .i_start      (w_start_ok),
      .i_launch     (w_launch),
      .i_len        (r_len),
      .i_guess      (r_g),
      .i_ram_q      (ram_q),
      .o_ram_addr   (ram_addr),
      .o_hit        (w_hit),
      .o_last       (w_last),
      .o_hit_mask   (hit_mask),
      .o_revealed   (revealed)
   );

   // Skipped guesses still pass through one SCAN cycle so done lands after E0+2.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_start_ok) w_state_nxt = S_SCAN;
         S_SCAN:  if (r_skip || w_last) w_state_nxt = S_DRAIN;
         S_DRAIN: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (new_word) w_state_nxt = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (resetn) begin
         r_state     <= S_IDLE;
         r_len       <= '0;
         r_g         <= '0;
         r_skip      <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_match     <= 1'b0;
         r_hit_count <= '0;
         r_remain    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= 1'b0;
         if (new_word) begin
            r_len       <= clamp_len(word_len);
            r_remain    <= clamp_len(word_len);
            r_hit_count <= '0;
            r_match     <= 1'b0;
            r_busy      <= 1'b0;
            r_skip      <= 1'b0;
         end else begin
            if (w_start_ok) begin
               r_g         <= guess;
               r_busy      <= 1'b1;
               r_hit_count <= '0;
               r_match     <= 1'b0;
               r_skip      <= w_skip;
            end
            if (w_hit) begin
               r_hit_count <= r_hit_count + ADDR_W'(1);
               if (r_remain != '0) r_remain <= r_remain - ADDR_W'(1);
            end
            if (r_state == S_DRAIN) begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_match <= (r_hit_count != '0);
            end
         end
      end
   end

`ifdef GUESS_SCANNER_REPEAT_EN
   always_ff @(posedge clk) begin
      if (resetn) begin
         r_hist   <= '0;
         r_rep    <= 1'b0;
         r_repeat <= 1'b0;
      end else begin
         r_repeat <= 1'b0;
         if (new_word) begin
            r_hist <= '0;
            r_rep  <= 1'b0;
         end else begin
            if (w_start_ok) begin
               r_rep <= w_rep;
               if (!w_rep && guess != KEY_NONE) r_hist[guess] <= 1'b1;
            end
            if (r_state == S_DRAIN) r_repeat <= r_rep;
         end
      end
   end
   assign is_repeat = r_repeat;
`endif

   a_no_underflow: assert property (@(posedge clk) disable iff (resetn)
      !(w_hit && !new_word && r_remain == '0));

   assign busy      = r_busy;
   assign done      = r_done;
   assign match     = r_match;
   assign hit_count = r_hit_count;
   assign remain    = r_remain;
   assign all_found = (r_remain == '0) && (r_len != '0);
endmodule

// File: tb/tb_guess_scanner.sv
// Scoreboard bench for guess_scanner: reference model predicts each done.
module tb_guess_scanner;
   import hangman_pkg::*;

   logic               clk = 1'b0;
   logic               resetn, new_word, start;
   logic [ADDR_W-1:0]  word_len;
   logic [CHAR_W-1:0]  guess, ram_q;
   logic [ADDR_W-1:0]  ram_addr, hit_count, remain;
   logic               busy, done, match, all_found;
   logic [MAX_LEN-1:0] hit_mask, revealed;
`ifdef GUESS_SCANNER_REPEAT_EN
   logic               is_repeat;
`endif

   guess_scanner dut (
      .clk(clk), .resetn(resetn), .new_word(new_word), .word_len(word_len),
      .start(start), .guess(guess), .ram_addr(ram_addr), .ram_q(ram_q),
      .busy(busy), .done(done), .match(match), .hit_count(hit_count),
      .hit_mask(hit_mask), .revealed(revealed), .remain(remain), .all_found(all_found)
`ifdef GUESS_SCANNER_REPEAT_EN
      , .is_repeat(is_repeat)
`endif
   );

   always #5 clk = ~clk;

   logic [CHAR_W-1:0] mem [32];
   always @(posedge clk) ram_q <= mem[ram_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          match;
      int          hc;
      bit [15:0]   mask;
      bit [15:0]   rev;
      int          remain;
      bit          allf;
      int          due;
      bit          rep;
   } exp_t;

   exp_t q[$];
   exp_t e_mon;
   int checks = 0;
   int errors = 0;

   int        m_len = 0;
   int        m_remain = 0;
   bit [15:0] m_rev = '0;
   bit [31:0] m_hist = '0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            e_mon = q.pop_front();
            chk("done_cycle", cyc, e_mon.due);
            chk("match", int'(match), int'(e_mon.match));
            chk("hit_count", int'(hit_count), e_mon.hc);
            chk("hit_mask", int'(hit_mask), int'(e_mon.mask));
            chk("revealed", int'(revealed), int'(e_mon.rev));
            chk("remain", int'(remain), e_mon.remain);
            chk("all_found", int'(all_found), int'(e_mon.allf));
`ifdef GUESS_SCANNER_REPEAT_EN
            chk("repeat", int'(is_repeat), int'(e_mon.rep));
`endif
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input int wl);
      new_word = 1'b1;
      word_len = wl[ADDR_W-1:0];
      tick();
      new_word = 1'b0;
      m_len    = (wl > MAX_LEN) ? MAX_LEN : wl;
      m_remain = m_len;
      m_rev    = '0;
      m_hist   = '0;
   endtask

   task automatic issue_guess(input int g);
      exp_t e;
      bit   rep;
      rep    = 1'b0;
`ifdef GUESS_SCANNER_REPEAT_EN
      rep = m_hist[g];
      if (!rep && g != 0) m_hist[g] = 1'b1;
`endif
      e.mask = '0;
      e.hc   = 0;
      if (!rep && m_len != 0 && g != 0) begin
         for (int i = 0; i < m_len; i++) begin
            if (int'(mem[i]) == g && !m_rev[i]) begin
               e.mask[i] = 1'b1;
               m_rev[i]  = 1'b1;
               e.hc++;
               m_remain--;
            end
         end
         e.due = cyc + 1 + m_len + 2;
      end else begin
         e.due = cyc + 1 + 2;
      end
      e.match  = (e.hc != 0);
      e.rev    = m_rev;
      e.remain = m_remain;
      e.allf   = (m_remain == 0) && (m_len != 0);
      e.rep    = rep;
      q.push_back(e);
      start = 1'b1;
      guess = g[CHAR_W-1:0];
      tick();
      start = 1'b0;
      guess = CHAR_W'($urandom_range(0, 31));
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((q.size() != 0 || busy) && n < 200) begin
         tick();
         n++;
      end
      chk("scan_timeout", int'(n < 200), 1);
      tick();
      tick();
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int wl;
      resetn = 1'b1; new_word = 1'b0; start = 1'b0; word_len = '0; guess = '0;
      for (int i = 0; i < 32; i++) mem[i] = '0;
      tick(); tick(); tick();
      resetn = 1'b0;
      @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_remain", int'(remain), 0);
      chk("rst_revealed", int'(revealed), 0);
      chk("rst_all_found", int'(all_found), 0);
      chk("rst_ram_addr", int'(ram_addr), 0);
      tick();

      // word "ABA"
      mem[0] = 5'd1; mem[1] = 5'd2; mem[2] = 5'd1;
      load_word(3);
      issue_guess(1); wait_idle();
      issue_guess(2); wait_idle();
      issue_guess(1); wait_idle();

      // absent guess, zero guess, start while busy
      mem[0] = 5'd3; mem[1] = 5'd1; mem[2] = 5'd4; mem[3] = 5'd1; mem[4] = 5'd5;
      load_word(5);
      issue_guess(7); wait_idle();
      issue_guess(0); wait_idle();
      issue_guess(4);
      start = 1'b1; guess = 5'd1; tick(); start = 1'b0;
      tick();
      start = 1'b1; guess = 5'd3; tick(); start = 1'b0;
      wait_idle();

      load_word(0);
      issue_guess(3); wait_idle();

      // new_word mid-scan aborts
      load_word(5);
      issue_guess(1);
      new_word = 1'b1; word_len = 5'd4; q.delete();
      tick();
      new_word = 1'b0;
      m_len = 4; m_remain = 4; m_rev = '0; m_hist = '0;
      @(negedge clk);
      chk("abort_busy", int'(busy), 0);
      chk("abort_revealed", int'(revealed), 0);
      chk("abort_remain", int'(remain), 4);
      repeat (10) tick();
      issue_guess(1); wait_idle();

      // reset mid-scan
      load_word(5);
      issue_guess(5);
      tick();
      resetn = 1'b1; q.delete();
      tick();
      resetn = 1'b0;
      m_len = 0; m_remain = 0; m_rev = '0; m_hist = '0;
      @(negedge clk);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_match", int'(match), 0);
      chk("midrst_hit_count", int'(hit_count), 0);
      chk("midrst_hit_mask", int'(hit_mask), 0);
      chk("midrst_revealed", int'(revealed), 0);
      chk("midrst_remain", int'(remain), 0);
      chk("midrst_ram_addr", int'(ram_addr), 0);
      tick();

      // length clamp
      for (int i = 0; i < 32; i++) mem[i] = 5'd2;
      load_word(20);
      chk("clamp_remain", int'(remain), 16);
      issue_guess(2); wait_idle();

      // randomized words and guesses
      for (int w = 0; w < 12; w++) begin
         for (int i = 0; i < 32; i++) mem[i] = CHAR_W'($urandom_range(1, 6));
         wl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(17, 31)) : int'($urandom_range(0, 16));
         load_word(wl);
         for (int k = 0; k < 12; k++) begin
            issue_guess(int'($urandom_range(0, 7)));
            wait_idle();
         end
      end

      repeat (5) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
